// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states
// and the RV32I load funct3 encodings.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } lsu_size_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RESP  = 2'd1,
      WRITE = 2'd2
   } lsu_state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam int DATA_W = 32;

   // funct3[1:0]: 00 byte, 01 half, 1x word
   function automatic lsu_size_t decode_size(input logic [1:0] sz);
      if (sz[1])
         return SZ_WORD;
      else if (sz[0])
         return SZ_HALF;
      else
         return SZ_BYTE;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract with sign/zero extension, and the
// byte/half merge into an old word used for read-modify-write stores.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] load_word,
   input  logic [1:0]  load_off,
   input  lsu_size_t   load_size,
   input  logic        load_unsigned,
   output logic [31:0] load_data,
   input  logic [31:0] old_word,
   input  logic [31:0] store_data,
   input  logic [1:0]  store_off,
   input  lsu_size_t   store_size,
   output logic [31:0] new_word
);

   function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic uns);
      logic signed [7:0]  b_s;
      logic signed [31:0] ext;
      b_s = b;
      ext = b_s;
      return uns ? {24'd0, b} : ext;
   endfunction

   function automatic logic [31:0] extend_half(input logic [15:0] h, input logic uns);
      logic signed [15:0] h_s;
      logic signed [31:0] ext;
      h_s = h;
      ext = h_s;
      return uns ? {16'd0, h} : ext;
   endfunction

   always_comb begin
      load_data = load_word;
      case (load_size)
         SZ_BYTE: load_data = extend_byte(load_word[{load_off, 3'b000} +: 8], load_unsigned);
         SZ_HALF: load_data = extend_half(load_word[{load_off[1], 4'b0000} +: 16], load_unsigned);
         default: load_data = load_word;
      endcase
   end

   // Only the addressed lanes change; everything else keeps the old word.
   always_comb begin
      new_word = old_word;
      case (store_size)
         SZ_BYTE: new_word[{store_off, 3'b000} +: 8]     = store_data[7:0];
         SZ_HALF: new_word[{store_off[1], 4'b0000} +: 16] = store_data[15:0];
         default: new_word = store_data;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-wide data memory; sub-word stores are
// read-modify-write. Define LSU_MISALIGN_TRAP_EN to flag misaligned accesses.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        misaligned,
   output logic [31:0] mem_address,
   output logic        mem_write_enable,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   lsu_state_t  state, state_next;

   logic [29:0] word_addr_q;
   logic [1:0]  off_q;
   lsu_size_t   size_q;
   logic [31:0] wdata_q;
   logic [31:0] old_word_q;
   logic [31:0] rdata_q;
   logic        mis_q;

   lsu_size_t   req_size;
   logic [1:0]  req_off;
   logic        req_mis;
   logic        accept;
   logic [31:0] load_data;
   logic [31:0] new_word;

   assign req_size = decode_size(req_funct3[1:0]);

   // Offsets are forced to natural alignment; with trapping enabled a
   // misaligned request never uses them since its data is discarded.
   always_comb begin
      req_off = req_addr[1:0];
      case (req_size)
         SZ_HALF: req_off = {req_addr[1], 1'b0};
         SZ_WORD: req_off = 2'b00;
         default: req_off = req_addr[1:0];
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign req_mis = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
   assign req_mis = 1'b0;
`endif

   assign accept = (state == IDLE) && req_valid;

   lsu_align u_align (
      .load_word     (mem_read_data),
      .load_off      (req_off),
      .load_size     (req_size),
      .load_unsigned (req_funct3[2]),
      .load_data     (load_data),
      .old_word      (old_word_q),
      .store_data    (wdata_q),
      .store_off     (off_q),
      .store_size    (size_q),
      .new_word      (new_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Request capture; outputs are gated by state, so these need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         word_addr_q <= req_addr[31:2];
         off_q       <= req_off;
         size_q      <= req_size;
         wdata_q     <= req_wdata;
         old_word_q  <= mem_read_data;
         rdata_q     <= (req_we || req_mis) ? 32'd0 : load_data;
         mis_q       <= req_mis;
      end
   end

   always_comb begin
      state_next       = state;
      req_ready        = 1'b0;
      resp_valid       = 1'b0;
      resp_rdata       = 32'd0;
      misaligned       = 1'b0;
      mem_address      = {word_addr_q, 2'b00};
      mem_write_enable = 1'b0;
      mem_write_data   = 32'd0;
      case (state)
         IDLE: begin
            req_ready   = 1'b1;
            mem_address = {req_addr[31:2], 2'b00};
            if (req_valid)
               state_next = (req_we && !req_mis) ? WRITE : RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_q;
            misaligned = mis_q;
            state_next = IDLE;
         end
         WRITE: begin
            mem_write_enable = 1'b1;
            mem_write_data   = new_word;
            resp_valid       = 1'b1;
            state_next       = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
